// File: rtl/maze_walk_engine.sv
// Map-driven walkability lookup: reads a cell and its four neighbours from an
// external walkable-tile map and returns the legal-move mask {down, up, right, left}.
module maze_walk_engine #(
  parameter int GRID_W  = 42,
  parameter int GRID_H  = 30,
  parameter int COORD_W = 10,
  parameter int MIRROR  = 1,
  parameter int WRAP_X  = 1,
  parameter int ADDR_W  = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               busy,
  output logic               map_rd,
  output logic [ADDR_W-1:0]  map_addr,
  input  logic               map_rdata,
  output logic               done,
  output logic [3:0]         dirs,
  output logic               err
);

  localparam int MAP_W = (MIRROR != 0) ? GRID_W / 2 : GRID_W;
  localparam int PW    = 2 * COORD_W + ADDR_W + 1;

  typedef enum logic [3:0] {IDLE, RD_C, RD_U, RD_D, RD_L, RD_R, WAIT, DONE, ERR} state_t;

  state_t             state, state_nxt;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] cx, cy, xm;
  logic [PW-1:0]      prod;
  logic [ADDR_W-1:0]  addr_now, addr_last;
  logic               rd_q, c_q, u_q, d_q, l_q;
  logic               out_of_range;

  assign out_of_range = ({1'b0, req_x} >= (COORD_W+1)'(GRID_W)) ||
                        ({1'b0, req_y} >= (COORD_W+1)'(GRID_H));

  // Cell addressed by the current read state; map_rd drops for walls past the edge.
  always_comb begin
    cx     = x_q;
    cy     = y_q;
    map_rd = 1'b0;
    case (state)
      RD_C: map_rd = 1'b1;
      RD_U: begin
        cy     = y_q - COORD_W'(1);
        map_rd = (y_q != '0);
      end
      RD_D: begin
        cy     = y_q + COORD_W'(1);
        map_rd = (y_q != COORD_W'(GRID_H - 1));
      end
      RD_L: begin
        if (x_q == '0) begin
          cx     = COORD_W'(GRID_W - 1);
          map_rd = (WRAP_X != 0);
        end else begin
          cx     = x_q - COORD_W'(1);
          map_rd = 1'b1;
        end
      end
      RD_R: begin
        if (x_q == COORD_W'(GRID_W - 1)) begin
          cx     = '0;
          map_rd = (WRAP_X != 0);
        end else begin
          cx     = x_q + COORD_W'(1);
          map_rd = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign xm       = ((MIRROR != 0) && (cx >= COORD_W'(GRID_W / 2))) ?
                    COORD_W'(GRID_W - 1) - cx : cx;
  assign prod     = PW'(cy) * PW'(MAP_W) + PW'(xm);
  assign addr_now = prod[ADDR_W-1:0];
  assign map_addr = map_rd ? addr_now : addr_last;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = out_of_range ? ERR : RD_C;
      RD_C:    state_nxt = RD_U;
      RD_U:    state_nxt = RD_D;
      RD_D:    state_nxt = RD_L;
      RD_L:    state_nxt = RD_R;
      RD_R:    state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data lags its strobe by one cycle, so each state captures the previous read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_last <= '0;
      rd_q      <= 1'b0;
      c_q       <= 1'b0;
      u_q       <= 1'b0;
      d_q       <= 1'b0;
      l_q       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dirs      <= '0;
    end else begin
      state <= state_nxt;
      rd_q  <= map_rd;
      done  <= 1'b0;
      if (map_rd) addr_last <= addr_now;
      if (state == IDLE && req) begin
        x_q <= req_x;
        y_q <= req_y;
      end
      case (state)
        RD_U: c_q <= rd_q & map_rdata;
        RD_D: u_q <= rd_q & map_rdata;
        RD_L: d_q <= rd_q & map_rdata;
        RD_R: l_q <= rd_q & map_rdata;
        WAIT: begin
          done <= 1'b1;
          err  <= 1'b0;
          dirs <= c_q ? {d_q, u_q, rd_q & map_rdata, l_q} : 4'b0000;
        end
        ERR: begin
          done <= 1'b1;
          err  <= 1'b1;
          dirs <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
